// File: rtl/iob_native_split_pkg.sv
// rtl/iob_native_split_pkg.sv - shared types and defaults for the CPU-to-IOb native splitter
// Holds the FSM state encoding, the error read-data default and the width helpers
// used to derive WSTRB_W and SEL_W from the top-level parameters.
package iob_native_split_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RWAIT  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int          ADDR_W_DEFAULT   = 32;
    localparam int          DATA_W_DEFAULT   = 32;
    localparam int          N_SLAVES_DEFAULT = 2;
    localparam int          TIMEOUT_DEFAULT  = 1024;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    function automatic int wstrb_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int sel_width(input int n_slaves);
        return $clog2(n_slaves);
    endfunction

endpackage

// File: rtl/iob_split_timeout.sv
// rtl/iob_split_timeout.sv - access timeout counter for the native splitter
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   clear      hold the counter at zero (FSM idle)
//   count_en   count this cycle (FSM waiting on the slave)
//   expire     high in the cycle the counter sits at TIMEOUT-1 while counting
module iob_split_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // The counter starts at 0 in the first waiting cycle, so expiry in the
    // cycle it shows TIMEOUT-1 gives exactly TIMEOUT waiting cycles.
    assign expire = count_en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/iob_native_split.sv
// rtl/iob_native_split.sv - splits one CPU native port into N_SLAVES IOb native ports
// Optional feature macro: IOB_NATIVE_SPLIT_TIMEOUT_EN (error completion after TIMEOUT
// waiting cycles; without it the FSM waits indefinitely and err_o stays 0).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cpu_valid_i/addr_i/wdata_i/wstrb_i   CPU request (wstrb 0 = read)
//   cpu_ready_o, cpu_rdata_o             one-cycle completion pulse and read data
//   m_avalid_o/addr_o/wdata_o/wstrb_o    per-slave request, slice i = slave i
//   m_ready_i, m_rvalid_i, m_rdata_i     per-slave accept, read valid, read data
//   err_o                                sticky timeout flag
module iob_native_split
    import iob_native_split_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter int                DATA_W   = DATA_W_DEFAULT,
    parameter int                N_SLAVES = N_SLAVES_DEFAULT,
    parameter int                TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_valid_i,
    input  logic [ADDR_W-1:0]             cpu_addr_i,
    input  logic [DATA_W-1:0]             cpu_wdata_i,
    input  logic [wstrb_width(DATA_W)-1:0] cpu_wstrb_i,
    output logic                          cpu_ready_o,
    output logic [DATA_W-1:0]             cpu_rdata_o,
    output logic [N_SLAVES-1:0]           m_avalid_o,
    output logic [N_SLAVES*ADDR_W-1:0]    m_addr_o,
    output logic [N_SLAVES*DATA_W-1:0]    m_wdata_o,
    output logic [N_SLAVES*wstrb_width(DATA_W)-1:0] m_wstrb_o,
    input  logic [N_SLAVES-1:0]           m_ready_i,
    input  logic [N_SLAVES-1:0]           m_rvalid_i,
    input  logic [N_SLAVES*DATA_W-1:0]    m_rdata_i,
    output logic                          err_o
);

    localparam int WSTRB_W = wstrb_width(DATA_W);
    localparam int SEL_W   = sel_width(N_SLAVES);

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [WSTRB_W-1:0] wstrb_q;
    logic [SEL_W-1:0]   sel_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;

    logic               sel_ready;
    logic               sel_rvalid;
    logic [DATA_W-1:0]  sel_rdata;
    logic               capture;
    logic               load_rdata;
    logic               load_err;
    logic               set_err;
    logic               expire;

    // Only the latched target's handshake and data are ever looked at.
    always_comb begin
        sel_ready  = 1'b0;
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready  = m_ready_i[i];
                sel_rvalid = m_rvalid_i[i];
                sel_rdata  = m_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        load_rdata = 1'b0;
        load_err   = 1'b0;
        set_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_valid_i) begin
                    capture   = 1'b1;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    state_nxt = (wstrb_q != '0) ? ST_DONE : ST_RWAIT;
                end else if (expire) begin
                    // Timed-out writes complete without touching rdata.
                    state_nxt = ST_DONE;
                    set_err   = 1'b1;
                    load_err  = (wstrb_q == '0);
                end
            end
            ST_RWAIT: begin
                if (sel_rvalid) begin
                    load_rdata = 1'b1;
                    state_nxt  = ST_DONE;
                end else if (expire) begin
                    load_err  = 1'b1;
                    set_err   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            sel_q   <= '0;
        end else if (capture) begin
            addr_q  <= cpu_addr_i;
            wdata_q <= cpu_wdata_i;
            wstrb_q <= cpu_wstrb_i;
            sel_q   <= cpu_addr_i[ADDR_W-1 -: SEL_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (load_rdata) begin
                rdata_q <= sel_rdata;
            end else if (load_err) begin
                rdata_q <= ERR_DATA;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Request outputs are decoded from the registered state, so they are
    // glitch-free with respect to CPU inputs and zero outside ACCESS.
    always_comb begin
        m_avalid_o = '0;
        m_addr_o   = '0;
        m_wdata_o  = '0;
        m_wstrb_o  = '0;
        if (state == ST_ACCESS) begin
            for (int i = 0; i < N_SLAVES; i++) begin
                if (sel_q == SEL_W'(i)) begin
                    m_avalid_o[i]                     = 1'b1;
                    m_addr_o[i*ADDR_W +: ADDR_W]      = addr_q;
                    m_wdata_o[i*DATA_W +: DATA_W]     = wdata_q;
                    m_wstrb_o[i*WSTRB_W +: WSTRB_W]   = wstrb_q;
                end
            end
        end
    end

    assign cpu_ready_o = (state == ST_DONE);
    assign cpu_rdata_o = rdata_q;

`ifdef IOB_NATIVE_SPLIT_TIMEOUT_EN
    iob_split_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == ST_IDLE),
        .count_en ((state == ST_ACCESS) || (state == ST_RWAIT)),
        .expire   (expire)
    );
    assign err_o = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^{TIMEOUT, err_q};
    assign expire         = 1'b0;
    assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_iob_native_split.sv
// tb/tb_iob_native_split.sv - scoreboard testbench for iob_native_split
module tb_iob_native_split;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int NS = 2;

    typedef struct {
        logic [DW-1:0] rdata;
        int            cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_valid_i = 1'b0;
    logic [AW-1:0]     cpu_addr_i = '0;
    logic [DW-1:0]     cpu_wdata_i = '0;
    logic [SW-1:0]     cpu_wstrb_i = '0;
    logic              cpu_ready_o;
    logic [DW-1:0]     cpu_rdata_o;
    logic [NS-1:0]     m_avalid_o;
    logic [NS*AW-1:0]  m_addr_o;
    logic [NS*DW-1:0]  m_wdata_o;
    logic [NS*SW-1:0]  m_wstrb_o;
    logic [NS-1:0]     m_ready_i;
    logic [NS-1:0]     m_rvalid_i;
    logic [NS*DW-1:0]  m_rdata_i;
    logic              err_o;

    iob_native_split #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .N_SLAVES (NS),
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_valid_i (cpu_valid_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_wstrb_i (cpu_wstrb_i),
        .cpu_ready_o (cpu_ready_o),
        .cpu_rdata_o (cpu_rdata_o),
        .m_avalid_o  (m_avalid_o),
        .m_addr_o    (m_addr_o),
        .m_wdata_o   (m_wdata_o),
        .m_wstrb_o   (m_wstrb_o),
        .m_ready_i   (m_ready_i),
        .m_rvalid_i  (m_rvalid_i),
        .m_rdata_i   (m_rdata_i),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Slave model: ready after rdy_wait avalid cycles, rvalid rv_wait cycles after read accept.
    int            rdy_wait[NS];
    int            rv_wait[NS];
    bit            mute[NS];
    logic [DW-1:0] resp_data[NS];
    int            acnt[NS];
    int            rcnt[NS];
    bit            rpend[NS];

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (m_avalid_o[i] && !m_ready_i[i]) acnt[i] <= acnt[i] + 1;
            else acnt[i] <= 0;
            if (m_avalid_o[i] && m_ready_i[i] && (m_wstrb_o[i*SW +: SW] == '0)) begin
                rpend[i] <= 1'b1;
                rcnt[i]  <= 0;
            end else if (rpend[i]) begin
                if (m_rvalid_i[i]) rpend[i] <= 1'b0;
                else rcnt[i] <= rcnt[i] + 1;
            end
        end
    end

    always_comb begin
        m_ready_i  = '0;
        m_rvalid_i = '0;
        m_rdata_i  = '0;
        for (int i = 0; i < NS; i++) begin
            m_ready_i[i]  = m_avalid_o[i] && (acnt[i] == rdy_wait[i]) && !mute[i];
            m_rvalid_i[i] = rpend[i] && (rcnt[i] == rv_wait[i]) && !mute[i];
            m_rdata_i[i*DW +: DW] = m_rvalid_i[i] ? resp_data[i] : 32'h0;
        end
    end

    // Scoreboard and request monitor.
    exp_t          sbq[$];
    exp_t          mon_e;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [SW-1:0] exp_wstrb;
    int            exp_sel;
    int            av_cnt[NS];
    int            done_cyc;
    logic [DW-1:0] last_rdata = '0;
    logic [NS*AW-1:0] ea;
    logic [NS*DW-1:0] ed;
    logic [NS*SW-1:0] es;

    always @(negedge clk) begin
        if (cpu_ready_o) begin
            if (sbq.size() == 0) begin
                check("spurious_ready", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
                mon_e = sbq.pop_front();
                check("rdata", 64'(cpu_rdata_o), 64'(mon_e.rdata));
                check("ready_cycle", 64'(cyc), 64'(mon_e.cyc));
                done_cyc = cyc;
            end
        end
        if (m_avalid_o != '0) begin
            ea = '0;
            ed = '0;
            es = '0;
            ea[exp_sel*AW +: AW] = exp_addr;
            ed[exp_sel*DW +: DW] = exp_wdata;
            es[exp_sel*SW +: SW] = exp_wstrb;
            check("avalid_onehot", 64'(m_avalid_o), 64'(1 << exp_sel));
            check("m_addr", 64'(m_addr_o), 64'(ea));
            check("m_wdata", 64'(m_wdata_o), 64'(ed));
            check("m_wstrb", 64'(m_wstrb_o), 64'(es));
            for (int i = 0; i < NS; i++) if (m_avalid_o[i]) av_cnt[i]++;
        end
    end

    int issue_cyc;

    // Called just after a rising edge; the request is sampled on the next edge.
    task automatic issue(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] wstrb, input int lat, input logic [DW-1:0] rd_exp);
        exp_t e;
        cpu_valid_i = 1'b1;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        cpu_wstrb_i = wstrb;
        exp_addr    = addr;
        exp_wdata   = wdata;
        exp_wstrb   = wstrb;
        exp_sel     = int'(addr[AW-1]);
        av_cnt[0]   = 0;
        av_cnt[1]   = 0;
        if (wstrb == '0) last_rdata = rd_exp;
        e.rdata = last_rdata;
        e.cyc   = cyc + lat;
        sbq.push_back(e);
        issue_cyc = cyc;
    endtask

    // Scrambles the CPU inputs after capture, waits for completion, drops valid.
    task automatic finish_access();
        bit seen = 1'b0;
        @(posedge clk);
        #1;
        cpu_addr_i  = cpu_addr_i ^ 32'h8000_0044;
        cpu_wdata_i = ~cpu_wdata_i;
        cpu_wstrb_i = ~cpu_wstrb_i;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (cpu_ready_o) seen = 1'b1;
        end
        if (!seen) begin
            check("completion_timeout", 64'd0, 64'd1);
            sbq.delete();
        end
        @(posedge clk);
        #1;
        cpu_valid_i = 1'b0;
        cpu_wstrb_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NS; i++) begin
            rdy_wait[i]  = 0;
            rv_wait[i]   = 0;
            mute[i]      = 1'b0;
            resp_data[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(cpu_ready_o), 64'd0);
        check("rst_rdata", 64'(cpu_rdata_o), 64'd0);
        check("rst_avalid", 64'(m_avalid_o), 64'd0);
        check("rst_addr", 64'(m_addr_o), 64'd0);
        check("rst_wdata", 64'(m_wdata_o), 64'd0);
        check("rst_wstrb", 64'(m_wstrb_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write to slave 0, immediate ready.
        issue(32'h0000_0010, 32'h1122_3344, 4'hF, 2, 32'h0);
        finish_access();
        check("w0_av0_cycles", 64'(av_cnt[0]), 64'd1);
        check("w0_av1_cycles", 64'(av_cnt[1]), 64'd0);

        // Read from slave 1, ready low 3 cycles, rvalid one cycle after ready.
        rdy_wait[1]  = 3;
        resp_data[1] = 32'hCAFE_F00D;
        issue(32'h8000_0004, 32'h0, 4'h0, 6, 32'hCAFE_F00D);
        finish_access();
        check("r1_av1_cycles", 64'(av_cnt[1]), 64'd4);
        check("r1_av0_cycles", 64'(av_cnt[0]), 64'd0);

        // Back-to-back: read slave 0 then write slave 1.
        rv_wait[0]   = 1;
        resp_data[0] = 32'h0BAD_C0DE;
        rdy_wait[1]  = 1;
        issue(32'h0000_0020, 32'h0, 4'h0, 4, 32'h0BAD_C0DE);
        finish_access();
        issue(32'h8000_0100, 32'h55AA_55AA, 4'h3, 3, 32'h0);
        check("b2b_start", 64'(issue_cyc), 64'(done_cyc + 1));
        finish_access();
        check("b2b_av1_cycles", 64'(av_cnt[1]), 64'd2);

        // Reset during RWAIT; the late rvalid must be ignored.
        rdy_wait[1]  = 0;
        rv_wait[1]   = 5;
        resp_data[1] = 32'h7777_7777;
        issue(32'h8000_0008, 32'h0, 4'h0, 8, 32'h7777_7777);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst         = 1'b1;
        cpu_valid_i = 1'b0;
        sbq.delete();
        last_rdata  = '0;
        @(negedge clk);
        check("mid_rst_ready", 64'(cpu_ready_o), 64'd0);
        check("mid_rst_rdata", 64'(cpu_rdata_o), 64'd0);
        check("mid_rst_avalid", 64'(m_avalid_o), 64'd0);
        check("mid_rst_addr", 64'(m_addr_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_idle_avalid", 64'(m_avalid_o), 64'd0);
        check("post_rst_rdata", 64'(cpu_rdata_o), 64'd0);
        rv_wait[0] = 0;
        issue(32'h0000_0040, 32'hA5A5_0001, 4'h1, 2, 32'h0);
        finish_access();
        resp_data[0] = 32'h1234_5678;
        issue(32'h0000_0044, 32'h0, 4'h0, 3, 32'h1234_5678);
        finish_access();

`ifdef IOB_NATIVE_SPLIT_TIMEOUT_EN
        // rvalid in the last counted cycle beats the timeout.
        rv_wait[0]   = 6;
        resp_data[0] = 32'h600D_DA7A;
        issue(32'h0000_0080, 32'h0, 4'h0, 9, 32'h600D_DA7A);
        finish_access();
        check("to_race_err", 64'(err_o), 64'd0);

        // Silent slave: error completion with ERR_DATA.
        mute[1] = 1'b1;
        issue(32'h8000_0000, 32'h0, 4'h0, 9, 32'hDEAD_BEEF);
        finish_access();
        check("to_err_set", 64'(err_o), 64'd1);
        mute[1]    = 1'b0;
        rv_wait[0] = 0;
        issue(32'h0000_0004, 32'h0000_00FF, 4'h1, 2, 32'h0);
        finish_access();
        check("to_err_sticky", 64'(err_o), 64'd1);
`else
        check("err_tied", 64'(err_o), 64'd0);
`endif

        repeat (3) @(posedge clk);
        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
